// File: rtl/riscv_pkg.sv
// Shared core types and constants: IF->ID buffer entry layout, reset PC and canonical NOP.
// Pure declarations, no latency; no flow control of its own.
// Consumers import riscv_pkg::* and size ports from the IFB_* widths.
package riscv_pkg;

  localparam int IFB_DATA_W = 32;
  localparam int IFB_ADDR_W = 32;
  localparam int IFB_INT_W  = 8;

  localparam logic [IFB_ADDR_W-1:0] IFB_RESET_ADDR = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [IFB_DATA_W-1:0] IFB_INST_NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [IFB_DATA_W-1:0] inst;
    logic [IFB_ADDR_W-1:0] addr;
    logic [IFB_INT_W-1:0]  int_flag;
  } ifb_entry_t;

endpackage

// File: rtl/inst_fetch_buf.sv
// IF->ID instruction FIFO holding {inst, word-aligned PC, interrupt flags}; flush empties it.
// Latency 1 cycle push->out_valid_o; 0 cycles when IFB_BYPASS_EN is defined and the buffer is empty.
// Backpressure: in_ready_o drops at full (even if popping); hold_i keeps the head entry in place.
module inst_fetch_buf #(
  parameter int                         DATA_W     = riscv_pkg::IFB_DATA_W,
  parameter int                         ADDR_W     = riscv_pkg::IFB_ADDR_W,
  parameter int                         INT_W      = riscv_pkg::IFB_INT_W,
  parameter int                         DEPTH      = 4,
  parameter logic [ADDR_W-1:0]          RESET_ADDR = riscv_pkg::IFB_RESET_ADDR,
  parameter logic [DATA_W-1:0]          INST_NOP   = riscv_pkg::IFB_INST_NOP,
  localparam int                        CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  interrupt_flag_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  interrupt_flag_o,
  output logic [CNT_W-1:0]  count_o
);
  import riscv_pkg::*;

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  ifb_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  ifb_entry_t in_entry;
  ifb_entry_t head_entry;
  logic       empty;
  logic       push;
  logic       pop;
  logic       bypass_vld;
  logic       bypass_take;

  always_comb begin
    in_entry.inst     = inst_i;
    in_entry.addr     = inst_addr_i & ~ADDR_W'(3);
    in_entry.int_flag = interrupt_flag_i;
  end

  assign empty      = (count_q == '0);
  assign in_ready_o = (count_q != FULL_CNT);

`ifdef IFB_BYPASS_EN
  // An empty buffer forwards the fetch beat straight to decode; it is only
  // stored when decode is holding and cannot take it this cycle.
  assign bypass_vld  = empty & in_valid_i & ~flush_i;
  assign bypass_take = bypass_vld & ~hold_i;
`else
  assign bypass_vld  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push = in_valid_i & in_ready_o & ~flush_i & ~bypass_take;
  assign pop  = ~empty & ~hold_i & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is never read before it has been written.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  always_comb begin
    head_entry.inst     = INST_NOP;
    head_entry.addr     = RESET_ADDR;
    head_entry.int_flag = '0;
    out_valid_o         = 1'b0;
    if (!empty) begin
      head_entry  = mem_q[rd_ptr_q];
      out_valid_o = 1'b1;
    end else if (bypass_vld) begin
      head_entry  = in_entry;
      out_valid_o = 1'b1;
    end
  end

  assign inst_o           = head_entry.inst;
  assign inst_addr_o      = head_entry.addr;
  assign interrupt_flag_o = head_entry.int_flag;
  assign count_o          = count_q;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed self-checking bench for inst_fetch_buf; expectations follow IFB_BYPASS_EN when defined.
module tb_inst_fetch_buf;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        hold_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [7:0]  interrupt_flag_i;
  logic        out_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [7:0]  interrupt_flag_o;
  logic [2:0]  count_o;

  int tests_run    = 0;
  int tests_failed = 0;

  inst_fetch_buf dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n_i),
    .flush_i          (flush_i),
    .hold_i           (hold_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .inst_i           (inst_i),
    .inst_addr_i      (inst_addr_i),
    .interrupt_flag_i (interrupt_flag_i),
    .out_valid_o      (out_valid_o),
    .inst_o           (inst_o),
    .inst_addr_o      (inst_addr_o),
    .interrupt_flag_o (interrupt_flag_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    in_valid_i = 1'b1; inst_i = 32'h1234_5678; inst_addr_i = 32'h40; interrupt_flag_i = 8'h01;
    step();
    step();
    in_valid_i = 1'b0;
    #1;
    tests_run++;
    if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
    tests_run++;
    if (inst_o !== 32'h0000_0013) begin tests_failed++; $display("FAIL reset_inst got %h want 00000013", inst_o); end
    tests_run++;
    if (count_o !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count_o); end
    tests_run++;
    if (in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
    tests_run++;
    if (inst_addr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %h want 0", inst_addr_o); end
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_fill();
    hold_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1; inst_i = 32'hA000_0000 + i;
      inst_addr_i = 32'h101 + 4 * i; interrupt_flag_i = 8'h00;
      step();
    end
    in_valid_i = 1'b1; inst_i = 32'hA000_0004; inst_addr_i = 32'h111;
    #1;
    tests_run++;
    if (count_o !== 3'd4) begin tests_failed++; $display("FAIL fill_count got %0d want 4", count_o); end
    tests_run++;
    if (in_ready_o !== 1'b0) begin tests_failed++; $display("FAIL fill_in_ready got %b want 0", in_ready_o); end
    tests_run++;
    if (inst_addr_o !== 32'h100) begin tests_failed++; $display("FAIL fill_head_addr got %h want 00000100", inst_addr_o); end
    tests_run++;
    if (inst_o !== 32'hA000_0000) begin tests_failed++; $display("FAIL fill_head_inst got %h want a0000000", inst_o); end
    step();
    step();
    tests_run++;
    if (count_o !== 3'd4) begin tests_failed++; $display("FAIL fill_stalled_count got %0d want 4", count_o); end
  endtask

  task automatic test_drain_wrap();
    logic [31:0] exp_addr [5];
    logic [31:0] exp_inst [5];
    int          k = 0;
    logic        go;
    for (int i = 0; i < 5; i++) begin
      exp_addr[i] = 32'h100 + 4 * i;
      exp_inst[i] = 32'hA000_0000 + i;
    end
    hold_i = 1'b0;
    #1;
    tests_run++;
    if (in_ready_o !== 1'b0) begin tests_failed++; $display("FAIL drain_full_pop_ready got %b want 0", in_ready_o); end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) #1;
      if (out_valid_o === 1'b1) begin
        tests_run++;
        if (k >= 5) begin
          tests_failed++; $display("FAIL drain_extra_entry got addr %h want none", inst_addr_o);
        end else if (inst_addr_o !== exp_addr[k] || inst_o !== exp_inst[k]) begin
          tests_failed++;
          $display("FAIL drain_order idx %0d got %h/%h want %h/%h", k, inst_addr_o, inst_o, exp_addr[k], exp_inst[k]);
        end
        k++;
      end
      go = in_valid_i & in_ready_o;
      step();
      if (go) in_valid_i = 1'b0;
    end
    tests_run++;
    if (k !== 5) begin tests_failed++; $display("FAIL drain_total got %0d want 5", k); end
    tests_run++;
    if (count_o !== 3'd0) begin tests_failed++; $display("FAIL drain_final_count got %0d want 0", count_o); end
  endtask

  task automatic test_stream();
    int   exp_idx;
    logic has;
    int   exp_cnt;
    hold_i = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      in_valid_i       = (k < 20);
      inst_i           = 32'hB000_0000 + k;
      inst_addr_i      = 32'h200 + 4 * k;
      interrupt_flag_i = (k == 2) ? 8'h04 : 8'h00;
`ifdef IFB_BYPASS_EN
      exp_idx = k; has = (k < 20); exp_cnt = 0;
`else
      exp_idx = k - 1; has = (k > 0); exp_cnt = (k > 0) ? 1 : 0;
`endif
      #1;
      tests_run++;
      if (count_o !== 3'(exp_cnt)) begin tests_failed++; $display("FAIL stream_count cyc %0d got %0d want %0d", k, count_o, exp_cnt); end
      tests_run++;
      if (out_valid_o !== has) begin
        tests_failed++; $display("FAIL stream_valid cyc %0d got %b want %b", k, out_valid_o, has);
      end else if (has) begin
        if (inst_o !== 32'hB000_0000 + exp_idx || interrupt_flag_o !== ((exp_idx == 2) ? 8'h04 : 8'h00)) begin
          tests_failed++;
          $display("FAIL stream_data cyc %0d got %h/%h want %h/%h", k, inst_o, interrupt_flag_o,
                   32'hB000_0000 + exp_idx, (exp_idx == 2) ? 8'h04 : 8'h00);
        end
      end
      step();
    end
    interrupt_flag_i = 8'h00;
    tests_run++;
    if (count_o !== 3'd0) begin tests_failed++; $display("FAIL stream_final_count got %0d want 0", count_o); end
  endtask

  task automatic test_flush();
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1; inst_i = 32'hC000_0000 + i; inst_addr_i = 32'h400 + 4 * i;
      step();
    end
    inst_i = 32'hDEAD_BEEF; inst_addr_i = 32'h500; flush_i = 1'b1;
    #1;
    tests_run++;
    if (count_o !== 3'd3) begin tests_failed++; $display("FAIL flush_pre_count got %0d want 3", count_o); end
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    #1;
    tests_run++;
    if (count_o !== 3'd0) begin tests_failed++; $display("FAIL flush_count got %0d want 0", count_o); end
    tests_run++;
    if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid got %b want 0", out_valid_o); end
    tests_run++;
    if (inst_o !== 32'h0000_0013) begin tests_failed++; $display("FAIL flush_inst got %h want 00000013", inst_o); end
    in_valid_i = 1'b1; inst_i = 32'hE000_0000; inst_addr_i = 32'h600;
    step();
    in_valid_i = 1'b0;
    #1;
    tests_run++;
    if (count_o !== 3'd1 || inst_o !== 32'hE000_0000) begin
      tests_failed++; $display("FAIL flush_next_head got %0d/%h want 1/e0000000", count_o, inst_o);
    end
    hold_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    hold_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1; inst_i = 32'hF000_0000 + i; inst_addr_i = 32'h700 + 4 * i;
      step();
    end
    in_valid_i = 1'b0; rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1; hold_i = 1'b0;
    #1;
    tests_run++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid got count %0d valid %b want 0 0", count_o, out_valid_o);
    end
  endtask

  task automatic test_bypass();
    hold_i = 1'b0;
    in_valid_i = 1'b1; inst_i = 32'h00A0_0093; inst_addr_i = 32'h302; interrupt_flag_i = 8'h80;
    #1;
`ifdef IFB_BYPASS_EN
    tests_run++;
    if (out_valid_o !== 1'b1 || inst_o !== 32'h00A0_0093 || inst_addr_o !== 32'h300 || interrupt_flag_o !== 8'h80) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle got %b %h %h %h want 1 00a00093 00000300 80", out_valid_o, inst_o, inst_addr_o, interrupt_flag_o);
    end
    tests_run++;
    if (count_o !== 3'd0) begin tests_failed++; $display("FAIL bypass_count got %0d want 0", count_o); end
    step();
    in_valid_i = 1'b0;
    #1;
    tests_run++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL bypass_after got count %0d valid %b want 0 0", count_o, out_valid_o);
    end
`else
    tests_run++;
    if (out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL nobypass_same_cycle got %b want 0", out_valid_o); end
    step();
    in_valid_i = 1'b0;
    #1;
    tests_run++;
    if (out_valid_o !== 1'b1 || inst_o !== 32'h00A0_0093 || inst_addr_o !== 32'h300 || interrupt_flag_o !== 8'h80) begin
      tests_failed++;
      $display("FAIL nobypass_next_cycle got %b %h %h %h want 1 00a00093 00000300 80", out_valid_o, inst_o, inst_addr_o, interrupt_flag_o);
    end
    tests_run++;
    if (count_o !== 3'd1) begin tests_failed++; $display("FAIL nobypass_count got %0d want 1", count_o); end
    step();
    tests_run++;
    if (count_o !== 3'd0) begin tests_failed++; $display("FAIL nobypass_drain got %0d want 0", count_o); end
`endif
    interrupt_flag_i = 8'h00;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_stream();
    test_flush();
    test_reset_mid();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0t want completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
